// File: rtl/pcie_rx_mwr_axi_master.sv
// pcie_rx_mwr_axi_master
//   Takes one decoded PCIe Memory-Write TLP at a time and replays it as a single
//   AXI3 INCR write burst on a 128-bit master port. TLPs that are not 3DW MWr,
//   have a length outside 1..MAX_DW, are not 16-byte aligned or would cross a
//   4 KB page are consumed and counted as drops.
// Ports
//   clk, rst                  clock, synchronous active-high reset
//   tlp_valid_i/tlp_ready_o   TLP handshake (ready only while idle)
//   header_*_i, addr_i,       decoded TLP header, byte address and payload
//   data_i                    (DW0 at [31:0])
//   aw*_o / awready_i         AXI write address channel
//   w*_o / wready_i           AXI write data channel
//   bvalid_i, bid_i, bresp_i, AXI write response channel
//   bready_o
//   wr_cnt_o, drop_cnt_o,     saturating counts of good writes, dropped TLPs
//   err_cnt_o                 and bad write responses
module pcie_rx_mwr_axi_master #(
    parameter int AXI_ID_WIDTH = 4,
    parameter int MAX_DW       = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    tlp_valid_i,
    output logic                    tlp_ready_o,
    input  logic [2:0]              header_fmt_i,
    input  logic [4:0]              header_type_i,
    input  logic [2:0]              header_tc_i,
    input  logic [8:0]              header_length_i,
    input  logic [15:0]             header_requestID_i,
    input  logic [31:0]             addr_i,
    input  logic [MAX_DW*32-1:0]    data_i,
    output logic                    awvalid_o,
    input  logic                    awready_i,
    output logic [AXI_ID_WIDTH-1:0] awid_o,
    output logic [31:0]             awaddr_o,
    output logic [3:0]              awlen_o,
    output logic [2:0]              awsize_o,
    output logic [1:0]              awburst_o,
    output logic                    wvalid_o,
    input  logic                    wready_i,
    output logic [AXI_ID_WIDTH-1:0] wid_o,
    output logic [127:0]            wdata_o,
    output logic [15:0]             wstrb_o,
    output logic                    wlast_o,
    input  logic                    bvalid_i,
    output logic                    bready_o,
    input  logic [AXI_ID_WIDTH-1:0] bid_i,
    input  logic [1:0]              bresp_i,
    output logic [15:0]             wr_cnt_o,
    output logic [15:0]             drop_cnt_o,
    output logic [15:0]             err_cnt_o
);

    localparam int         DATA_BITS = MAX_DW * 32;
    localparam logic [8:0] MAX_LEN   = 9'(MAX_DW);

    typedef enum logic [1:0] {IDLE, BURST, RESP} state_t;

    state_t                  state_q, state_d;
    logic [AXI_ID_WIDTH-1:0] tag_q, tag_d;
    logic                    awvalid_q, awvalid_d;
    logic                    wvalid_q, wvalid_d;
    logic                    bready_q, bready_d;
    logic                    aw_done_q, aw_done_d;
    logic                    w_done_q, w_done_d;
    logic [3:0]              beat_q, beat_d;
    logic [3:0]              awlen_q, awlen_d;
    logic [1:0]              len_lo_q, len_lo_d;
    logic [31:0]             addr_q, addr_d;
    logic [DATA_BITS-1:0]    data_q, data_d;
    logic [15:0]             wr_cnt_q, wr_cnt_d;
    logic [15:0]             drop_cnt_q, drop_cnt_d;
    logic [15:0]             err_cnt_q, err_cnt_d;

    logic [13:0] end_addr;
    logic [9:0]  len_p3;
    logic        legal;
    logic        aw_hs;
    logic        w_hs;
    logic        unused_sig;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Partial final beat: only the low length[1:0] DWs carry payload.
    function automatic logic [15:0] last_strb(input logic [1:0] len_lo);
        case (len_lo)
            2'd1:    return 16'h000F;
            2'd2:    return 16'h00FF;
            2'd3:    return 16'h0FFF;
            default: return 16'hFFFF;
        endcase
    endfunction

    // 14 bits hold page offset + payload bytes without overflow.
    assign end_addr = {2'b00, addr_i[11:0]} + {3'b000, header_length_i, 2'b00};
    assign len_p3   = {1'b0, header_length_i} + 10'd3;
    assign legal    = (header_fmt_i == 3'b010) && (header_type_i == 5'b00000) &&
                      (header_length_i != 9'd0) && (header_length_i <= MAX_LEN) &&
                      (addr_i[3:0] == 4'h0) && (end_addr <= 14'd4096);

    assign aw_hs = awvalid_q & awready_i;
    assign w_hs  = wvalid_q & wready_i;

    assign unused_sig = ^{header_tc_i, header_requestID_i, len_p3[9:6], len_p3[1:0]};

    always_comb begin
        state_d    = state_q;
        tag_d      = tag_q;
        awvalid_d  = awvalid_q;
        wvalid_d   = wvalid_q;
        bready_d   = bready_q;
        aw_done_d  = aw_done_q;
        w_done_d   = w_done_q;
        beat_d     = beat_q;
        awlen_d    = awlen_q;
        len_lo_d   = len_lo_q;
        addr_d     = addr_q;
        data_d     = data_q;
        wr_cnt_d   = wr_cnt_q;
        drop_cnt_d = drop_cnt_q;
        err_cnt_d  = err_cnt_q;
        case (state_q)
            IDLE: begin
                if (tlp_valid_i) begin
                    if (legal) begin
                        addr_d    = addr_i;
                        data_d    = data_i;
                        awlen_d   = len_p3[5:2] - 4'd1;
                        len_lo_d  = header_length_i[1:0];
                        beat_d    = 4'd0;
                        aw_done_d = 1'b0;
                        w_done_d  = 1'b0;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        state_d   = BURST;
                    end else begin
                        drop_cnt_d = sat_inc(drop_cnt_q);
                    end
                end
            end
            BURST: begin
                if (aw_hs) begin
                    awvalid_d = 1'b0;
                    aw_done_d = 1'b1;
                end
                if (w_hs) begin
                    if (wlast_o) begin
                        wvalid_d = 1'b0;
                        w_done_d = 1'b1;
                    end else begin
                        // Shift the payload so the next beat is always in the low 128 bits.
                        beat_d = beat_q + 4'd1;
                        data_d = data_q >> 128;
                    end
                end
                if ((aw_done_q || aw_hs) && (w_done_q || (w_hs && wlast_o))) begin
                    bready_d = 1'b1;
                    state_d  = RESP;
                end
            end
            RESP: begin
                if (bvalid_i && bready_q) begin
                    if (bid_i == tag_q && bresp_i == 2'b00) begin
                        wr_cnt_d = sat_inc(wr_cnt_q);
                    end else begin
                        err_cnt_d = sat_inc(err_cnt_q);
                    end
                    tag_d    = tag_q + AXI_ID_WIDTH'(1);
                    bready_d = 1'b0;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        addr_q   <= addr_d;
        data_q   <= data_d;
        awlen_q  <= awlen_d;
        len_lo_q <= len_lo_d;
        beat_q   <= beat_d;
        if (rst) begin
            state_q    <= IDLE;
            tag_q      <= '0;
            awvalid_q  <= 1'b0;
            wvalid_q   <= 1'b0;
            bready_q   <= 1'b0;
            aw_done_q  <= 1'b0;
            w_done_q   <= 1'b0;
            wr_cnt_q   <= 16'd0;
            drop_cnt_q <= 16'd0;
            err_cnt_q  <= 16'd0;
        end else begin
            state_q    <= state_d;
            tag_q      <= tag_d;
            awvalid_q  <= awvalid_d;
            wvalid_q   <= wvalid_d;
            bready_q   <= bready_d;
            aw_done_q  <= aw_done_d;
            w_done_q   <= w_done_d;
            wr_cnt_q   <= wr_cnt_d;
            drop_cnt_q <= drop_cnt_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    assign tlp_ready_o = (state_q == IDLE) && !rst;
    assign awvalid_o   = awvalid_q;
    assign awid_o      = tag_q;
    assign awaddr_o    = addr_q;
    assign awlen_o     = awlen_q;
    assign awsize_o    = 3'b100;
    assign awburst_o   = 2'b01;
    assign wvalid_o    = wvalid_q;
    assign wid_o       = tag_q;
    assign wdata_o     = data_q[127:0];
    assign wlast_o     = (beat_q == awlen_q);
    assign wstrb_o     = wlast_o ? last_strb(len_lo_q) : 16'hFFFF;
    assign bready_o    = bready_q;
    assign wr_cnt_o    = wr_cnt_q;
    assign drop_cnt_o  = drop_cnt_q;
    assign err_cnt_o   = err_cnt_q;

endmodule

// File: tb/tb_pcie_rx_mwr_axi_master.sv
module tb_pcie_rx_mwr_axi_master;

    logic          clk = 1'b0;
    logic          rst;
    logic          tlp_valid, tlp_ready;
    logic [2:0]    fmt, tc;
    logic [4:0]    typ;
    logic [8:0]    len;
    logic [15:0]   reqid;
    logic [31:0]   addr;
    logic [1023:0] data;
    logic          awvalid, awready, wvalid, wready, wlast, bvalid, bready;
    logic [3:0]    awid, wid, bid, awlen;
    logic [31:0]   awaddr;
    logic [2:0]    awsize;
    logic [1:0]    awburst, bresp;
    logic [127:0]  wdata;
    logic [15:0]   wstrb, wr_cnt, drop_cnt, err_cnt;

    always #5 clk = ~clk;

    pcie_rx_mwr_axi_master #(.AXI_ID_WIDTH(4), .MAX_DW(32)) dut (
        .clk(clk), .rst(rst), .tlp_valid_i(tlp_valid), .tlp_ready_o(tlp_ready),
        .header_fmt_i(fmt), .header_type_i(typ), .header_tc_i(tc),
        .header_length_i(len), .header_requestID_i(reqid), .addr_i(addr), .data_i(data),
        .awvalid_o(awvalid), .awready_i(awready), .awid_o(awid), .awaddr_o(awaddr),
        .awlen_o(awlen), .awsize_o(awsize), .awburst_o(awburst),
        .wvalid_o(wvalid), .wready_i(wready), .wid_o(wid), .wdata_o(wdata),
        .wstrb_o(wstrb), .wlast_o(wlast),
        .bvalid_i(bvalid), .bready_o(bready), .bid_i(bid), .bresp_i(bresp),
        .wr_cnt_o(wr_cnt), .drop_cnt_o(drop_cnt), .err_cnt_o(err_cnt)
    );

    int tests = 0;
    int fails = 0;

    // Reference model state
    int         exp_wr, exp_drop, exp_err;
    logic [3:0] exp_tag;

    // Observations collected by run_burst
    logic [31:0]  o_awaddr;
    logic [3:0]   o_awlen, o_awid;
    logic [2:0]   o_awsize;
    logic [1:0]   o_awburst;
    int           o_unstable, o_early_b, o_timeout, o_aw_c, o_w_c, nb;
    logic [127:0] wd[16];
    logic [15:0]  ws[16];
    logic         wl[16];
    logic [3:0]   wi[16];

    function automatic int exp_beats(input int l);
        return (l + 3) / 4;
    endfunction

    function automatic logic [15:0] exp_strb(input int l, input int k);
        int bytes;
        bytes = l * 4 - 16 * k;
        if (bytes >= 16) return 16'hFFFF;
        return 16'((1 << bytes) - 1);
    endfunction

    function automatic logic [1023:0] rand_data();
        logic [1023:0] d;
        for (int i = 0; i < 32; i++) d[32*i +: 32] = $urandom();
        return d;
    endfunction

    function automatic logic [31:0] rand_legal_addr(input int l);
        int off;
        off = $urandom_range(0, (4096 - l * 4) / 16) * 16;
        return ($urandom() & 32'hFFFF_F000) | 32'(off);
    endfunction

    task automatic send_tlp(input logic [2:0] f, input logic [4:0] t, input logic [8:0] l,
                            input logic [31:0] a, input logic [1023:0] d);
        int k;
        k = 0;
        while (tlp_ready !== 1'b1 && k < 50) begin
            @(negedge clk);
            k++;
        end
        tests++;
        if (tlp_ready !== 1'b1) begin
            fails++;
            $display("FAIL tlp_ready_wait: tlp_ready=%b required 1", tlp_ready);
        end
        fmt = f; typ = t; len = l; addr = a; data = d;
        tc = 3'($urandom()); reqid = 16'($urandom());
        tlp_valid = 1'b1;
        @(negedge clk);
        tlp_valid = 1'b0;
    endtask

    // Drives the AW/W/B slave side for one burst and records what the DUT presented.
    task automatic run_burst(input int aw_delay, input bit w_rand, input int b_delay,
                             input logic [1:0] resp, input bit bad_bid);
        bit aw_seen, aw_got, w_fin, w_pend;
        logic [127:0] pd;
        logic [15:0]  ps;
        logic         pl;
        int k;
        aw_seen = 0; aw_got = 0; w_fin = 0; w_pend = 0;
        pd = '0; ps = '0; pl = 0;
        nb = 0; o_unstable = 0; o_early_b = 0; o_timeout = 0; o_aw_c = -1; o_w_c = -1;
        for (int c = 0; c < 300 && !(aw_got && w_fin); c++) begin
            awready = (c >= aw_delay);
            wready  = w_rand ? 1'($urandom_range(0, 1)) : 1'b1;
            if (bready === 1'b1) o_early_b++;
            if (awvalid === 1'b1) begin
                if (!aw_seen) begin
                    o_awaddr = awaddr; o_awlen = awlen; o_awid = awid;
                    o_awsize = awsize; o_awburst = awburst;
                    aw_seen = 1;
                end else if ({awaddr, awlen, awid, awsize, awburst} !==
                             {o_awaddr, o_awlen, o_awid, o_awsize, o_awburst}) begin
                    o_unstable++;
                end
                if (awready) begin
                    aw_got = 1;
                    o_aw_c = c;
                end
            end
            if (wvalid === 1'b1) begin
                if (w_pend && {wdata, wstrb, wlast} !== {pd, ps, pl}) o_unstable++;
                if (wready) begin
                    if (nb < 16) begin
                        wd[nb] = wdata; ws[nb] = wstrb; wl[nb] = wlast; wi[nb] = wid;
                    end
                    nb++;
                    w_pend = 0;
                    if (wlast === 1'b1) begin
                        w_fin = 1;
                        o_w_c = c;
                    end
                end else begin
                    w_pend = 1; pd = wdata; ps = wstrb; pl = wlast;
                end
            end
            @(negedge clk);
        end
        awready = 1'b0;
        wready  = 1'b0;
        if (!(aw_got && w_fin)) o_timeout = 1;
        repeat (b_delay) @(negedge clk);
        bvalid = 1'b1;
        bid    = exp_tag ^ {3'b000, bad_bid};
        bresp  = resp;
        k = 0;
        while (bready !== 1'b1 && k < 50) begin
            @(negedge clk);
            k++;
        end
        if (bready !== 1'b1) o_timeout = 1;
        @(negedge clk);
        bvalid = 1'b0;
        if (resp == 2'b00 && !bad_bid) exp_wr++;
        else exp_err++;
        exp_tag++;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        tests++;
        if ({tlp_ready, awvalid, wvalid, bready} !== 4'b0000) begin
            fails++;
            $display("FAIL reset_ctrl: ready/awv/wv/bready=%b required 0000",
                     {tlp_ready, awvalid, wvalid, bready});
        end
        tests++;
        if ({wr_cnt, drop_cnt, err_cnt, awid} !== 52'd0) begin
            fails++;
            $display("FAIL reset_cnt: wr=%0d drop=%0d err=%0d tag=%0d required all 0",
                     wr_cnt, drop_cnt, err_cnt, awid);
        end
        rst = 1'b0;
        exp_wr = 0; exp_drop = 0; exp_err = 0; exp_tag = 0;
        @(negedge clk);
        tests++;
        if (tlp_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_release_ready: %b required 1", tlp_ready);
        end
    endtask

    task automatic test_single();
        logic [1023:0] d;
        for (int i = 0; i < 32; i++) d[32*i +: 32] = 32'h0123_4567;
        send_tlp(3'b010, 5'b00000, 9'd4, 32'h0, d);
        run_burst(0, 0, 0, 2'b00, 0);
        tests++;
        if ({o_awaddr, o_awlen, o_awsize, o_awburst, o_awid} !==
            {32'h0, 4'd0, 3'b100, 2'b01, 4'd0}) begin
            fails++;
            $display("FAIL single_aw: addr=%h len=%0d size=%b burst=%b id=%0d required 0/0/100/01/0",
                     o_awaddr, o_awlen, o_awsize, o_awburst, o_awid);
        end
        tests++;
        if (nb !== 1 || {wd[0], ws[0], wl[0]} !== {d[127:0], 16'hFFFF, 1'b1}) begin
            fails++;
            $display("FAIL single_w: beats=%0d data=%h strb=%h last=%b required 1/%h/ffff/1",
                     nb, wd[0], ws[0], wl[0], d[127:0]);
        end
        tests++;
        if (wr_cnt !== 16'd1 || awid !== 4'd1 || o_timeout != 0) begin
            fails++;
            $display("FAIL single_cnt: wr=%0d tag=%0d timeout=%0d required 1/1/0",
                     wr_cnt, awid, o_timeout);
        end
    endtask

    task automatic test_multi_beat();
        logic [1023:0] d;
        logic [3:0]    t0;
        d  = rand_data();
        t0 = exp_tag;
        send_tlp(3'b010, 5'b00000, 9'd9, 32'h20, d);
        run_burst(0, 0, 0, 2'b00, 0);
        tests++;
        if (o_awaddr !== 32'h20 || o_awlen !== 4'd2 || nb !== 3) begin
            fails++;
            $display("FAIL multi_aw: addr=%h awlen=%0d beats=%0d required 20/2/3",
                     o_awaddr, o_awlen, nb);
        end
        for (int k = 0; k < 3; k++) begin
            tests++;
            if ({wd[k], ws[k], wl[k], wi[k]} !==
                {d[128*k +: 128], exp_strb(9, k), (k == 2), t0}) begin
                fails++;
                $display("FAIL multi_beat%0d: data=%h strb=%h last=%b wid=%0d required %h/%h/%b/%0d",
                         k, wd[k], ws[k], wl[k], wi[k], d[128*k +: 128], exp_strb(9, k),
                         (k == 2), t0);
            end
        end
    endtask

    task automatic test_illegal();
        logic [2:0]  f[5]  = '{3'b000, 3'b010, 3'b010, 3'b010, 3'b011};
        logic [8:0]  l[5]  = '{9'd4, 9'd8, 9'd0, 9'd33, 9'd4};
        logic [31:0] a[5]  = '{32'h0, 32'hFF0, 32'h100, 32'h0, 32'h204};
        logic [1023:0] d;
        for (int i = 0; i < 5; i++) begin
            send_tlp(f[i], 5'b00000, l[i], a[i], rand_data());
            exp_drop++;
            tests++;
            if ({awvalid, wvalid, tlp_ready} !== 3'b001) begin
                fails++;
                $display("FAIL illegal%0d: awv/wv/ready=%b required 001", i,
                         {awvalid, wvalid, tlp_ready});
            end
        end
        tests++;
        if (drop_cnt !== 16'(exp_drop)) begin
            fails++;
            $display("FAIL drop_cnt: %0d required %0d", drop_cnt, exp_drop);
        end
        // Ends exactly on a page boundary: still legal.
        d = rand_data();
        send_tlp(3'b010, 5'b00000, 9'd8, 32'h1FE0, d);
        run_burst(0, 0, 0, 2'b00, 0);
        tests++;
        if (o_awaddr !== 32'h1FE0 || nb !== 2 || wd[1] !== d[255:128] || wr_cnt !== 16'(exp_wr)) begin
            fails++;
            $display("FAIL page_edge: addr=%h beats=%0d wr=%0d required 1fe0/2/%0d",
                     o_awaddr, nb, wr_cnt, exp_wr);
        end
    endtask

    task automatic test_aw_stall();
        logic [1023:0] d;
        d = rand_data();
        send_tlp(3'b010, 5'b00000, 9'd8, 32'h4000_0040, d);
        run_burst(5, 0, 0, 2'b00, 0);
        tests++;
        if (o_unstable != 0 || o_early_b != 0 || o_timeout != 0) begin
            fails++;
            $display("FAIL aw_stall_hold: unstable=%0d early_b=%0d timeout=%0d required 0/0/0",
                     o_unstable, o_early_b, o_timeout);
        end
        tests++;
        if (!(o_w_c >= 0 && o_w_c < o_aw_c) || nb !== 2 ||
            {wd[0], wd[1]} !== {d[127:0], d[255:128]}) begin
            fails++;
            $display("FAIL aw_stall_order: w_done_cycle=%0d aw_cycle=%0d beats=%0d required w before aw, 2 beats",
                     o_w_c, o_aw_c, nb);
        end
        tests++;
        if (o_awaddr !== 32'h4000_0040 || o_awlen !== 4'd1) begin
            fails++;
            $display("FAIL aw_stall_fields: addr=%h len=%0d required 40000040/1", o_awaddr, o_awlen);
        end
    endtask

    task automatic test_bad_resp();
        int         wr0;
        logic [3:0] t0;
        wr0 = exp_wr;
        t0  = exp_tag;
        send_tlp(3'b010, 5'b00000, 9'd4, 32'h80, rand_data());
        run_burst(0, 0, 1, 2'b10, 0);
        send_tlp(3'b010, 5'b00000, 9'd4, 32'h90, rand_data());
        run_burst(0, 0, 0, 2'b00, 1);
        tests++;
        if (err_cnt !== 16'd2 || wr_cnt !== 16'(wr0)) begin
            fails++;
            $display("FAIL bad_resp_cnt: err=%0d wr=%0d required 2/%0d", err_cnt, wr_cnt, wr0);
        end
        tests++;
        if (awid !== 4'(t0 + 4'd2)) begin
            fails++;
            $display("FAIL bad_resp_tag: %0d required %0d", awid, 4'(t0 + 4'd2));
        end
    endtask

    task automatic test_random();
        logic [1023:0] d;
        logic [31:0]   a;
        logic [3:0]    t0;
        int            l, nbe, bad;
        for (int it = 0; it < 20; it++) begin
            l  = $urandom_range(1, 32);
            a  = rand_legal_addr(l);
            d  = rand_data();
            t0 = exp_tag;
            send_tlp(3'b010, 5'b00000, 9'(l), a, d);
            run_burst($urandom_range(0, 3), 1, $urandom_range(0, 2), 2'b00, 0);
            nbe = exp_beats(l);
            bad = 0;
            for (int k = 0; k < nbe && k < 16; k++)
                if ({wd[k], ws[k], wl[k], wi[k]} !==
                    {d[128*k +: 128], exp_strb(l, k), (k == nbe - 1), t0}) bad++;
            tests++;
            if ({o_awaddr, o_awlen, o_awid, o_awsize, o_awburst} !==
                {a, 4'(nbe - 1), t0, 3'b100, 2'b01} || nb != nbe) begin
                fails++;
                $display("FAIL rand%0d_aw: addr=%h len=%0d id=%0d beats=%0d required %h/%0d/%0d/%0d",
                         it, o_awaddr, o_awlen, o_awid, nb, a, nbe - 1, t0, nbe);
            end
            tests++;
            if (bad != 0 || o_unstable != 0 || o_early_b != 0 || o_timeout != 0) begin
                fails++;
                $display("FAIL rand%0d_w: bad_beats=%0d unstable=%0d early_b=%0d timeout=%0d required 0/0/0/0 (len %0d)",
                         it, bad, o_unstable, o_early_b, o_timeout, l);
            end
        end
        tests++;
        if (wr_cnt !== 16'(exp_wr) || awid !== exp_tag) begin
            fails++;
            $display("FAIL rand_cnt: wr=%0d tag=%0d required %0d/%0d", wr_cnt, awid, exp_wr, exp_tag);
        end
    endtask

    task automatic test_reset_mid_burst();
        logic [1023:0] d;
        d = rand_data();
        send_tlp(3'b010, 5'b00000, 9'd12, 32'h100, d);
        awready = 1'b0;
        wready  = 1'b1;
        @(negedge clk);
        tests++;
        if (wvalid !== 1'b1 || wdata !== d[255:128]) begin
            fails++;
            $display("FAIL rst_mid_beat1: wvalid=%b data=%h required 1/%h", wvalid, wdata, d[255:128]);
        end
        rst    = 1'b1;
        wready = 1'b0;
        @(negedge clk);
        tests++;
        if ({awvalid, wvalid, bready, tlp_ready} !== 4'b0000 ||
            {wr_cnt, drop_cnt, err_cnt, awid} !== 52'd0) begin
            fails++;
            $display("FAIL rst_mid_state: v=%b wr=%0d drop=%0d err=%0d tag=%0d required 0000/0/0/0/0",
                     {awvalid, wvalid, bready, tlp_ready}, wr_cnt, drop_cnt, err_cnt, awid);
        end
        rst = 1'b0;
        exp_wr = 0; exp_drop = 0; exp_err = 0; exp_tag = 0;
        d = rand_data();
        send_tlp(3'b010, 5'b00000, 9'd6, 32'h300, d);
        run_burst(1, 0, 0, 2'b00, 0);
        tests++;
        if (o_awid !== 4'd0 || nb !== 2 || wd[1] !== d[255:128] || ws[1] !== 16'h00FF ||
            wr_cnt !== 16'd1 || awid !== 4'd1) begin
            fails++;
            $display("FAIL rst_mid_after: id=%0d beats=%0d strb=%h wr=%0d tag=%0d required 0/2/00ff/1/1",
                     o_awid, nb, ws[1], wr_cnt, awid);
        end
    endtask

    task automatic test_drop_saturation();
        fmt = 3'b000; typ = 5'b00000; len = 9'd4; addr = 32'h0;
        tlp_valid = 1'b1;
        repeat (65540) @(negedge clk);
        tests++;
        if (drop_cnt !== 16'hFFFF || tlp_ready !== 1'b1 || awvalid !== 1'b0) begin
            fails++;
            $display("FAIL drop_sat: drop=%h ready=%b awvalid=%b required ffff/1/0",
                     drop_cnt, tlp_ready, awvalid);
        end
        tlp_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; tlp_valid = 1'b0; fmt = '0; typ = '0; tc = '0; len = '0; reqid = '0;
        addr = '0; data = '0; awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bid = '0; bresp = '0;
        exp_wr = 0; exp_drop = 0; exp_err = 0; exp_tag = 0;
        test_reset();
        test_single();
        test_multi_beat();
        test_illegal();
        test_aw_stall();
        test_bad_resp();
        test_random();
        test_reset_mid_burst();
        test_drop_saturation();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
